// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the system ID and build timestamp words
// and reports whether both match the expected values, or that a read timed out.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1519654004,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    // state    | meaning
    // S_IDLE   | waiting for start, bus idle
    // S_RD_ID  | read of word 0 (ID) outstanding
    // S_RD_TS  | read of word 1 (timestamp) outstanding
    // S_FINISH | done pulse cycle, results final
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RD_ID  = 2'd1;
    localparam logic [1:0] S_RD_TS  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    // Abort fires on the TIMEOUT_CYCLES-th stall cycle, i.e. when the count
    // of earlier stall cycles already equals TIMEOUT_CYCLES-1.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [15:0] wait_cnt;
    logic        wait_expired;
    logic        id_match;
    logic        ts_match;

    assign wait_expired = (wait_cnt == WAIT_LAST);
    assign id_match     = (avm_readdata == EXPECTED_ID);
    assign ts_match     = (avm_readdata == EXPECTED_TIMESTAMP);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            wait_cnt    <= 16'd0;
            avm_address <= 1'b0;
            avm_read    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pass        <= 1'b0;
                        id_ok       <= 1'b0;
                        ts_ok       <= 1'b0;
                        timeout     <= 1'b0;
                        avm_address <= 1'b0;
                        avm_read    <= 1'b1;
                        busy        <= 1'b1;
                        wait_cnt    <= 16'd0;
                        state       <= S_RD_ID;
                    end
                end
                S_RD_ID: begin
                    if (!avm_waitrequest) begin
                        id_value    <= avm_readdata;
                        id_ok       <= id_match;
                        avm_address <= 1'b1;
                        wait_cnt    <= 16'd0;
                        state       <= S_RD_TS;
                    end else if (wait_expired) begin
                        avm_read <= 1'b0;
                        timeout  <= 1'b1;
                        pass     <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_FINISH;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_RD_TS: begin
                    if (!avm_waitrequest) begin
                        ts_value <= avm_readdata;
                        ts_ok    <= ts_match;
                        pass     <= id_ok & ts_match;
                        avm_read <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_FINISH;
                    end else if (wait_expired) begin
                        avm_read <= 1'b0;
                        timeout  <= 1'b1;
                        pass     <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_FINISH;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
// Randomized scoreboard bench for sysid_checker: a reactive slave supplies
// stalls and data, a reference model predicts each check's outcome.
module tb_sysid_checker;

    localparam logic [31:0] EID = 32'd0;
    localparam logic [31:0] ETS = 32'd1519654004;
    localparam int unsigned T   = 8;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy, done, pass, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;

    sysid_checker #(
        .EXPECTED_ID       (EID),
        .EXPECTED_TIMESTAMP(ETS),
        .TIMEOUT_CYCLES    (T)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata   (avm_readdata),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .id_ok          (id_ok),
        .ts_ok          (ts_ok),
        .timeout        (timeout),
        .id_value       (id_value),
        .ts_value       (ts_value)
    );

    typedef struct {
        int unsigned done_cyc;
        logic        pass;
        logic        id_ok;
        logic        ts_ok;
        logic        timeout;
        logic [31:0] id_value;
        logic [31:0] ts_value;
        int unsigned rd0;
        int unsigned rd1;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned stall_left[2];
    logic [31:0] data_cfg[2];
    int unsigned rd_cnt[2];
    logic [31:0] prev_id = 32'd0;
    logic [31:0] prev_ts = 32'd0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reactive slave: per-address stall budget, then zero-latency data.
    always @(negedge clock) begin
        if (avm_read === 1'b1) begin
            rd_cnt[avm_address]++;
            if (stall_left[avm_address] > 0) begin
                avm_waitrequest = 1'b1;
                stall_left[avm_address]--;
                avm_readdata = $urandom;
            end else begin
                avm_waitrequest = 1'b0;
                avm_readdata = data_cfg[avm_address];
            end
        end else begin
            avm_waitrequest = 1'($urandom_range(0, 1));
            avm_readdata = $urandom;
        end
    end

    // Monitor: every done pulse must match the oldest prediction.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_cycle", cyc, e.done_cyc);
                chk("pass", {31'd0, pass}, {31'd0, e.pass});
                chk("id_ok", {31'd0, id_ok}, {31'd0, e.id_ok});
                chk("ts_ok", {31'd0, ts_ok}, {31'd0, e.ts_ok});
                chk("timeout", {31'd0, timeout}, {31'd0, e.timeout});
                chk("id_value", id_value, e.id_value);
                chk("ts_value", ts_value, e.ts_value);
                chk("read_cycles_addr0", rd_cnt[0], e.rd0);
                chk("read_cycles_addr1", rd_cnt[1], e.rd1);
                chk("read_low_at_done", {31'd0, avm_read}, 32'd0);
            end
        end
    end

    function automatic exp_t model(input int unsigned s0, input int unsigned s1,
                                   input logic [31:0] d0, input logic [31:0] d1,
                                   input int unsigned c0);
        exp_t e;
        e.id_value = prev_id;
        e.ts_value = prev_ts;
        e.id_ok = 1'b0;
        e.ts_ok = 1'b0;
        e.pass = 1'b0;
        e.timeout = 1'b0;
        e.rd0 = 0;
        e.rd1 = 0;
        if (s0 >= T) begin
            e.timeout = 1'b1;
            e.rd0 = T;
            e.done_cyc = c0 + T + 1;
        end else begin
            e.id_value = d0;
            e.id_ok = (d0 == EID);
            e.rd0 = s0 + 1;
            if (s1 >= T) begin
                e.timeout = 1'b1;
                e.rd1 = T;
                e.done_cyc = c0 + s0 + 1 + T + 1;
            end else begin
                e.ts_value = d1;
                e.ts_ok = (d1 == ETS);
                e.pass = e.id_ok && e.ts_ok;
                e.rd1 = s1 + 1;
                e.done_cyc = c0 + s0 + s1 + 3;
            end
        end
        return e;
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_avm_read"}, {31'd0, avm_read}, 32'd0);
        chk({tag, "_avm_address"}, {31'd0, avm_address}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_flags"}, {28'd0, pass, id_ok, ts_ok, timeout}, 32'd0);
        chk({tag, "_id_value"}, id_value, 32'd0);
        chk({tag, "_ts_value"}, ts_value, 32'd0);
    endtask

    task automatic run(input int unsigned s0, input int unsigned s1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input bit hold_start, input int unsigned reset_at);
        exp_t e;
        @(negedge clock);
        #1;
        stall_left[0] = s0;
        stall_left[1] = s1;
        data_cfg[0] = d0;
        data_cfg[1] = d1;
        rd_cnt[0] = 0;
        rd_cnt[1] = 0;
        e = model(s0, s1, d0, d1, cyc);
        q.push_back(e);
        start = 1'b1;
        @(negedge clock);
        #1;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("read_after_start", {31'd0, avm_read}, 32'd1);
        if (hold_start) begin
            @(negedge clock);
            @(negedge clock);
            #1;
        end
        start = 1'b0;
        if (reset_at > 0) begin
            for (int i = 1; i < reset_at; i++) @(negedge clock);
            #1 reset_n = 1'b0;
            #1 check_reset_values("mid_reset");
            q.delete();
            prev_id = 32'd0;
            prev_ts = 32'd0;
            repeat (3) @(negedge clock);
            #1 reset_n = 1'b1;
        end else begin
            for (int i = 0; i < 300 && q.size() > 0; i++) @(negedge clock);
            chk("run_completed", q.size(), 32'd0);
            q.delete();
            prev_id = e.id_value;
            prev_ts = e.ts_value;
        end
        repeat (3) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        avm_waitrequest = 1'b0;
        avm_readdata = 32'd0;
        stall_left[0] = 0;
        stall_left[1] = 0;
        data_cfg[0] = EID;
        data_cfg[1] = ETS;
        rd_cnt[0] = 0;
        rd_cnt[1] = 0;
        repeat (3) @(negedge clock);
        check_reset_values("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        run(0, 0, EID, ETS, 1'b0, 0);
        run(0, 0, EID, ETS + 32'd1, 1'b0, 0);
        run(4, 4, EID, ETS, 1'b0, 0);
        run(1000, 0, EID, ETS, 1'b0, 0);
        run(0, 0, EID, ETS, 1'b0, 0);
        run(2, 1000, 32'h1234, ETS, 1'b0, 0);
        run(7, 7, EID, ETS, 1'b0, 0);
        run(0, 0, EID, ETS, 1'b1, 0);
        run(0, 0, EID, ETS, 1'b0, 2);
        run(0, 0, EID, ETS, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            int unsigned s[2];
            logic [31:0] d0, d1;
            for (int k = 0; k < 2; k++) begin
                int unsigned r;
                r = $urandom_range(0, 9);
                if (r < 7)      s[k] = $urandom_range(0, 3);
                else if (r < 9) s[k] = $urandom_range(4, 7);
                else            s[k] = $urandom_range(8, 20);
            end
            d0 = ($urandom_range(0, 2) != 0) ? EID : $urandom;
            d1 = ($urandom_range(0, 2) != 0) ? ETS : $urandom;
            run(s[0], s[1], d0, d1, 1'($urandom_range(0, 1)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
